// File: rtl/snake_pkg.sv
// Shared widths, grid limits and FSM encoding for the snake prey placer.
// The optional raster fallback is enabled by defining SNAKE_PREY_FALLBACK_EN.
package snake_pkg;

    localparam int H_LOGIC_WIDTH = 5;
    localparam int V_LOGIC_WIDTH = 5;
    localparam int LEN_WIDTH     = 6;

    localparam logic [H_LOGIC_WIDTH-1:0] H_LOGIC_MAX = 5'd31;
    localparam logic [V_LOGIC_WIDTH-1:0] V_LOGIC_MAX = 5'd23;
    localparam logic [3:0]               MAX_RETRY   = 4'd15;

    typedef enum logic [2:0] {
        ST_REQ    = 3'd0,
        ST_WAIT   = 3'd1,
        ST_CHECK  = 3'd2,
        ST_SCAN   = 3'd3,
        ST_COMMIT = 3'd4,
        ST_IDLE   = 3'd5
    } state_t;

    // Compared at 32 bits so a max equal to the all-ones code is not a constant compare.
    function automatic logic off_grid(input logic [H_LOGIC_WIDTH-1:0] x,
                                      input logic [V_LOGIC_WIDTH-1:0] y);
        return (32'(x) > 32'(H_LOGIC_MAX)) || (32'(y) > 32'(V_LOGIC_MAX));
    endfunction

endpackage

// File: rtl/snake_seg_match.sv
// Aligns the body store's one-cycle read return with its issue tag and compares
// the returned segment against the candidate; yields hit and last-compared flags.
module snake_seg_match
    import snake_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enb,
    input  logic                     issue,
    input  logic                     issue_last,
    input  logic [H_LOGIC_WIDTH-1:0] segx,
    input  logic [V_LOGIC_WIDTH-1:0] segy,
    input  logic [H_LOGIC_WIDTH-1:0] candx,
    input  logic [V_LOGIC_WIDTH-1:0] candy,
    output logic                     hit,
    output logic                     last
);

    logic                     rd_valid;
    logic                     rd_last;
    logic                     fresh;
    logic [H_LOGIC_WIDTH-1:0] hold_x;
    logic [V_LOGIC_WIDTH-1:0] hold_y;
    logic [H_LOGIC_WIDTH-1:0] cmp_x;
    logic [V_LOGIC_WIDTH-1:0] cmp_y;

    // The store keeps reading the frozen address during a stall, so the return
    // that was in flight when enb dropped is parked here until enb comes back.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            fresh    <= 1'b0;
            hold_x   <= '0;
            hold_y   <= '0;
        end else begin
            fresh <= enb;
            if (fresh && !enb) begin
                hold_x <= segx;
                hold_y <= segy;
            end
            if (enb) begin
                rd_valid <= issue;
                rd_last  <= issue && issue_last;
            end
        end
    end

    assign cmp_x = fresh ? segx : hold_x;
    assign cmp_y = fresh ? segy : hold_y;
    assign hit   = rd_valid && (cmp_x == candx) && (cmp_y == candy);
    assign last  = rd_valid && rd_last;

endmodule

// File: rtl/snake_prey_placer.sv
// Requests prey candidates, rejects off-grid or body-overlapping ones, publishes the
// committed prey and detects the head eating it. Raster fallback: SNAKE_PREY_FALLBACK_EN.
module snake_prey_placer
    import snake_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enb,
    input  logic                     head_valid,
    input  logic [H_LOGIC_WIDTH-1:0] headx,
    input  logic [V_LOGIC_WIDTH-1:0] heady,
    input  logic [LEN_WIDTH-1:0]     snake_len,
    output logic [LEN_WIDTH-1:0]     seg_addr,
    input  logic [H_LOGIC_WIDTH-1:0] segx,
    input  logic [V_LOGIC_WIDTH-1:0] segy,
    output logic                     cand_req,
    input  logic [H_LOGIC_WIDTH-1:0] cand_x,
    input  logic [V_LOGIC_WIDTH-1:0] cand_y,
    output logic [H_LOGIC_WIDTH-1:0] preyx,
    output logic [V_LOGIC_WIDTH-1:0] preyy,
    output logic                     prey_valid,
    output logic                     eat,
    output state_t                   fsm_state
);

    localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

    state_t                   state;
    logic [H_LOGIC_WIDTH-1:0] candx_q;
    logic [V_LOGIC_WIDTH-1:0] candy_q;
    logic [LEN_WIDTH-1:0]     len_q;
    logic                     issue_done;
    logic                     req_q;
    logic                     eat_q;
    logic [3:0]               retry;
    logic [3:0]               retry_inc;
    logic                     issue;
    logic                     issue_last;
    logic                     seg_hit;
    logic                     seg_last;
    logic                     reject;
    logic                     head_on_prey;

    assign retry_inc    = (retry == 4'hF) ? 4'hF : retry + 4'd1;
    assign issue        = (state == ST_SCAN) && !issue_done;
    assign issue_last   = (seg_addr == len_q - LEN_ONE);
    assign reject       = ((state == ST_CHECK) && off_grid(candx_q, candy_q))
                       || ((state == ST_SCAN) && seg_hit);
    assign head_on_prey = head_valid && prey_valid && (headx == preyx) && (heady == preyy);

`ifdef SNAKE_PREY_FALLBACK_EN
    logic [H_LOGIC_WIDTH-1:0] nextx;
    logic [V_LOGIC_WIDTH-1:0] nexty;

    // Raster successor of the candidate: x first, then y, both wrapping at the grid edge.
    always_comb begin
        nextx = candx_q + H_LOGIC_WIDTH'(1);
        nexty = candy_q;
        if (32'(candx_q) >= 32'(H_LOGIC_MAX)) begin
            nextx = '0;
            nexty = (32'(candy_q) >= 32'(V_LOGIC_MAX)) ? '0 : candy_q + V_LOGIC_WIDTH'(1);
        end
    end
`endif

    snake_seg_match u_seg_match (
        .clk        (clk),
        .rst        (rst),
        .enb        (enb),
        .issue      (issue),
        .issue_last (issue_last),
        .segx       (segx),
        .segy       (segy),
        .candx      (candx_q),
        .candy      (candy_q),
        .hit        (seg_hit),
        .last       (seg_last)
    );

    // REQ spends its first cycle raising the request when it was entered straight from reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_REQ;
            candx_q    <= '0;
            candy_q    <= '0;
            len_q      <= '0;
            seg_addr   <= '0;
            issue_done <= 1'b0;
            req_q      <= 1'b0;
            eat_q      <= 1'b0;
            retry      <= '0;
            preyx      <= '0;
            preyy      <= '0;
            prey_valid <= 1'b0;
        end else if (enb) begin
            req_q <= 1'b0;
            eat_q <= 1'b0;
            if (reject) begin
`ifdef SNAKE_PREY_FALLBACK_EN
                if (retry_inc >= MAX_RETRY) begin
                    if (retry < MAX_RETRY) begin
                        retry <= retry_inc;
                    end
                    candx_q <= nextx;
                    candy_q <= nexty;
                    state   <= ST_CHECK;
                end else begin
                    retry <= retry_inc;
                    req_q <= 1'b1;
                    state <= ST_REQ;
                end
`else
                retry <= retry_inc;
                req_q <= 1'b1;
                state <= ST_REQ;
`endif
            end else begin
                case (state)
                    ST_REQ: begin
                        if (req_q) begin
                            state <= ST_WAIT;
                        end else begin
                            req_q <= 1'b1;
                        end
                    end
                    ST_WAIT: begin
                        candx_q <= cand_x;
                        candy_q <= cand_y;
                        state   <= ST_CHECK;
                    end
                    ST_CHECK: begin
                        if (snake_len == '0) begin
                            state <= ST_COMMIT;
                        end else begin
                            len_q      <= snake_len;
                            seg_addr   <= '0;
                            issue_done <= 1'b0;
                            state      <= ST_SCAN;
                        end
                    end
                    ST_SCAN: begin
                        if (seg_last) begin
                            state <= ST_COMMIT;
                        end else if (!issue_done) begin
                            if (issue_last) begin
                                issue_done <= 1'b1;
                            end else begin
                                seg_addr <= seg_addr + LEN_ONE;
                            end
                        end
                    end
                    ST_COMMIT: begin
                        preyx      <= candx_q;
                        preyy      <= candy_q;
                        prey_valid <= 1'b1;
                        retry      <= '0;
                        state      <= ST_IDLE;
                    end
                    ST_IDLE: begin
                        if (head_on_prey) begin
                            eat_q      <= 1'b1;
                            prey_valid <= 1'b0;
                            req_q      <= 1'b1;
                            state      <= ST_REQ;
                        end
                    end
                    default: state <= ST_REQ;
                endcase
            end
        end
    end

    assign cand_req  = req_q && enb;
    assign eat       = eat_q && enb;
    assign fsm_state = state;

endmodule

// File: tb/tb_snake_prey_placer.sv
// Directed bench for snake_prey_placer: generator and body-store models, a commit
// scoreboard, and placement/eat/stall/reset scenarios (fallback case when its macro is defined).
module tb_snake_prey_placer;
    import snake_pkg::*;

    logic                     clk        = 1'b0;
    logic                     rst        = 1'b0;
    logic                     enb        = 1'b1;
    logic                     head_valid = 1'b0;
    logic [H_LOGIC_WIDTH-1:0] headx      = '0;
    logic [V_LOGIC_WIDTH-1:0] heady      = '0;
    logic [LEN_WIDTH-1:0]     snake_len  = '0;
    logic [LEN_WIDTH-1:0]     seg_addr;
    logic [H_LOGIC_WIDTH-1:0] segx       = '0;
    logic [V_LOGIC_WIDTH-1:0] segy       = '0;
    logic                     cand_req;
    logic [H_LOGIC_WIDTH-1:0] cand_x     = '0;
    logic [V_LOGIC_WIDTH-1:0] cand_y     = '0;
    logic [H_LOGIC_WIDTH-1:0] preyx;
    logic [V_LOGIC_WIDTH-1:0] preyy;
    logic                     prey_valid;
    logic                     eat;
    state_t                   fsm_state;

    snake_prey_placer dut (
        .clk        (clk),
        .rst        (rst),
        .enb        (enb),
        .head_valid (head_valid),
        .headx      (headx),
        .heady      (heady),
        .snake_len  (snake_len),
        .seg_addr   (seg_addr),
        .segx       (segx),
        .segy       (segy),
        .cand_req   (cand_req),
        .cand_x     (cand_x),
        .cand_y     (cand_y),
        .preyx      (preyx),
        .preyy      (preyy),
        .prey_valid (prey_valid),
        .eat        (eat),
        .fsm_state  (fsm_state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Generator model: answers each request the following cycle.
    logic [9:0] gen_q[$];
    logic [9:0] gen_default = '0;
    int         req_count   = 0;
    always @(posedge clk) begin
        if (cand_req) begin
            req_count <= req_count + 1;
            if (gen_q.size() > 0) {cand_x, cand_y} <= gen_q.pop_front();
            else                  {cand_x, cand_y} <= gen_default;
        end
    end

    // Body store model: synchronous read, data one cycle after the address.
    logic [H_LOGIC_WIDTH-1:0] memx[64];
    logic [V_LOGIC_WIDTH-1:0] memy[64];
    always @(posedge clk) begin
        segx <= memx[seg_addr];
        segy <= memy[seg_addr];
    end

    // Scoreboard and monitors.
    logic [9:0]           exp_q[$];
    logic [LEN_WIDTH-1:0] addr_log[$];
    logic                 pv_d      = 1'b0;
    logic                 scan_d    = 1'b0;
    logic [LEN_WIDTH-1:0] addr_d    = '0;
    int                   eat_count = 0;
    always @(negedge clk) begin
        if (prey_valid && !pv_d) begin
            logic [9:0] e;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 10'h3FF;
            check("prey_commit", {preyx, preyy}, e);
        end
        if (eat) eat_count <= eat_count + 1;
        if (enb && scan_d && fsm_state == ST_SCAN) addr_log.push_back(addr_d);
        pv_d   <= prey_valid;
        scan_d <= enb && (fsm_state == ST_SCAN);
        addr_d <= seg_addr;
    end

    task automatic hit_head(input logic [H_LOGIC_WIDTH-1:0] x, input logic [V_LOGIC_WIDTH-1:0] y);
        @(posedge clk);
        #1 head_valid = 1'b1; headx = x; heady = y;
        @(posedge clk);
        #1 head_valid = 1'b0;
    endtask

    task automatic wait_prey(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (prey_valid) break;
        end
        check(tag, prey_valid, 1);
    endtask

    task automatic wait_scan(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (fsm_state == ST_SCAN) break;
        end
        check(tag, fsm_state, ST_SCAN);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int                       base;
        int                       exp_eats;
        logic [H_LOGIC_WIDTH-1:0] cur_x;
        logic [V_LOGIC_WIDTH-1:0] cur_y;
        logic [LEN_WIDTH-1:0]     exp_addr[5];
        exp_addr = '{6'd0, 6'd1, 6'd0, 6'd1, 6'd2};
        exp_eats = 0;

        for (int i = 0; i < 64; i++) begin
            memx[i] = '0;
            memy[i] = '0;
        end
        memx[0] = 5'd4; memy[0] = 5'd4;
        memx[1] = 5'd5; memy[1] = 5'd4;
        memx[2] = 5'd6; memy[2] = 5'd4;

        // Reset values and first placement with an empty body.
        gen_q.push_back({5'd10, 5'd5});
        exp_q.push_back({5'd10, 5'd5});
        repeat (3) @(negedge clk);
        check("rst_preyx", preyx, 0);
        check("rst_preyy", preyy, 0);
        check("rst_prey_valid", prey_valid, 0);
        check("rst_eat", eat, 0);
        check("rst_cand_req", cand_req, 0);
        check("rst_seg_addr", seg_addr, 0);
        check("rst_state", fsm_state, ST_REQ);
        rst = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("t1_not_yet", prey_valid, 0);
        @(negedge clk);
        check("t1_latency", prey_valid, 1);
        check("t1_reqs", req_count, 1);
        cur_x = 5'd10; cur_y = 5'd5;

        // Off-grid candidate is rejected and re-requested.
        gen_q.push_back({5'd3, 5'd28});
        gen_q.push_back({5'd3, 5'd7});
        exp_q.push_back({5'd3, 5'd7});
        base = req_count;
        hit_head(cur_x, cur_y);
        exp_eats++;
        @(negedge clk);
        check("t2_eat", eat, 1);
        check("t2_prey_drop", prey_valid, 0);
        check("t2_req", cand_req, 1);
        wait_prey("t2_commit", 100);
        check("t2_reqs", req_count - base, 2);
        cur_x = 5'd3; cur_y = 5'd7;

        // Body overlap aborts the scan on the second segment.
        snake_len = 6'd3;
        addr_log.delete();
        gen_q.push_back({5'd5, 5'd4});
        gen_q.push_back({5'd9, 5'd9});
        exp_q.push_back({5'd9, 5'd9});
        base = req_count;
        hit_head(cur_x, cur_y);
        exp_eats++;
        @(negedge clk);
        check("t3_eat", eat, 1);
        wait_prey("t3_commit", 100);
        check("t3_reqs", req_count - base, 2);
        check("t3_addr_count", addr_log.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < addr_log.size()) check("t3_addr_seq", addr_log[i], exp_addr[i]);
        end
        cur_x = 5'd9; cur_y = 5'd9;

        // Near miss does not eat; exact hit eats and replaces with fixed latency.
        hit_head(5'd9, 5'd8);
        @(negedge clk);
        check("t4_miss_eat", eat, 0);
        check("t4_miss_valid", prey_valid, 1);
        @(negedge clk);
        check("t4_miss_eat2", eat, 0);
        gen_q.push_back({5'd20, 5'd20});
        exp_q.push_back({5'd20, 5'd20});
        hit_head(5'd9, 5'd9);
        exp_eats++;
        @(negedge clk);
        check("t4_eat", eat, 1);
        check("t4_prey_drop", prey_valid, 0);
        check("t4_req", cand_req, 1);
        @(negedge clk);
        check("t4_eat_pulse", eat, 0);
        repeat (6) @(negedge clk);
        check("t4_latency_early", prey_valid, 0);
        @(negedge clk);
        check("t4_latency", prey_valid, 1);
        cur_x = 5'd20; cur_y = 5'd20;

        // Stall mid-scan while the first segment's data is in flight.
        gen_q.push_back({5'd4, 5'd4});
        gen_q.push_back({5'd12, 5'd3});
        exp_q.push_back({5'd12, 5'd3});
        base = req_count;
        hit_head(cur_x, cur_y);
        exp_eats++;
        @(negedge clk);
        check("t5_eat", eat, 1);
        wait_scan("t5_reach_scan", 20);
        @(posedge clk);
        #1 enb = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t5_frz_addr", seg_addr, 1);
            check("t5_frz_state", fsm_state, ST_SCAN);
            check("t5_frz_valid", prey_valid, 0);
        end
        @(posedge clk);
        #1 enb = 1'b1;
        wait_prey("t5_commit", 100);
        check("t5_reqs", req_count - base, 2);
        cur_x = 5'd12; cur_y = 5'd3;

`ifdef SNAKE_PREY_FALLBACK_EN
        // Generator stuck on an occupied cell: raster fallback after the retry limit.
        gen_default = {5'd4, 5'd4};
        exp_q.push_back({5'd7, 5'd4});
        base = req_count;
        hit_head(cur_x, cur_y);
        exp_eats++;
        @(negedge clk);
        check("t6_eat", eat, 1);
        wait_prey("t6_commit", 600);
        check("t6_reqs", req_count - base, 15);
        gen_default = '0;
        cur_x = 5'd7; cur_y = 5'd4;
`endif

        // Asynchronous reset in the middle of a scan.
        gen_q.push_back({5'd30, 5'd1});
        hit_head(cur_x, cur_y);
        exp_eats++;
        @(negedge clk);
        check("rr_eat", eat, 1);
        wait_scan("rr_reach_scan", 20);
        @(posedge clk);
        #2 rst = 1'b0;
        exp_q.delete();
        gen_q.delete();
        #1;
        check("rr_state", fsm_state, ST_REQ);
        check("rr_seg_addr", seg_addr, 0);
        check("rr_prey_valid", prey_valid, 0);
        check("rr_preyx", preyx, 0);
        check("rr_cand_req", cand_req, 0);
        gen_q.push_back({5'd2, 5'd2});
        exp_q.push_back({5'd2, 5'd2});
        @(negedge clk);
        rst = 1'b1;
        wait_prey("rr_commit", 100);

        repeat (3) @(negedge clk);
        check("exp_q_drained", exp_q.size(), 0);
        check("eat_total", eat_count, exp_eats);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
